imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 69 ++++++
 rtl/imem_arbiter.sv | 149 ++++++++++++++
 tb/tb_imem_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory arbiter slice: default widths,
// port identifiers and the saturating counter helper.
package cpu_pkg;

   localparam int CPU_ADDR_W = 10;
   localparam int CPU_DATA_W = 32;
   localparam int CNT_W      = 16;

   typedef enum logic [0:0] {
      PORT_F = 1'b0,
      PORT_D = 1'b1
   } port_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: round-robin or fetch-priority with a debug starvation
// guard. Grants are combinational from the requests and the held state.
module rr_arb2
   import cpu_pkg::*;
#(
   parameter int FETCH_PRIO = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic f_req,
   input  logic d_req,
   output logic f_gnt,
   output logic d_gnt
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   port_e         last_r;
   logic [SW-1:0] starve_r;
   logic          d_wins_tie_s;

   // Tie resolution and grant generation; no grant while reset is asserted.
   always_comb begin
      d_wins_tie_s = 1'b0;
      f_gnt        = 1'b0;
      d_gnt        = 1'b0;
      if (FETCH_PRIO != 0) begin
         d_wins_tie_s = (starve_r == SW'(STARVE_MAX));
      end else begin
         d_wins_tie_s = (last_r == PORT_F);
      end
      if (rst) begin
         f_gnt = 1'b0;
         d_gnt = 1'b0;
      end else if (f_req && d_req) begin
         f_gnt = !d_wins_tie_s;
         d_gnt = d_wins_tie_s;
      end else begin
         f_gnt = f_req;
         d_gnt = d_req;
      end
   end

   // Last-granted pointer and debug starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_r   <= PORT_D;
         starve_r <= {SW{1'b0}};
      end else begin
         if (f_gnt) begin
            last_r <= PORT_F;
         end else if (d_gnt) begin
            last_r <= PORT_D;
         end else begin
            last_r <= last_r;
         end
         // Saturates at the threshold so it can never wrap past it.
         if (d_gnt) begin
            starve_r <= {SW{1'b0}};
         end else if (d_req && (starve_r != SW'(STARVE_MAX))) begin
            starve_r <= starve_r + SW'(1);
         end else begin
            starve_r <= starve_r;
         end
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one combinational instruction ROM between a fetch port and a debug
// port through a two-stage pipeline: 2-cycle latency, one access per cycle.
module imem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = CPU_ADDR_W,
   parameter int DATA_W     = CPU_DATA_W,
   parameter int ROM_DEPTH  = 1024,
   parameter int FETCH_PRIO = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_valid,
   output logic [DATA_W-1:0] f_rdata,
   output logic              f_err,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [CNT_W-1:0]  f_cnt,
   output logic [CNT_W-1:0]  d_cnt
);

   logic              s1_valid_r;
   logic [ADDR_W-1:0] addr_q_r;
   port_e             sel_q_r;
   logic              oor_s;
   logic [DATA_W-1:0] rdata_s;
   logic              f_valid_r, d_valid_r, f_err_r, d_err_r;
   logic [DATA_W-1:0] f_rdata_r, d_rdata_r;
   logic [CNT_W-1:0]  f_cnt_r, d_cnt_r;

   rr_arb2 #(
      .FETCH_PRIO(FETCH_PRIO),
      .STARVE_MAX(STARVE_MAX)
   ) u_arb (
      .clk  (clk),
      .rst  (rst),
      .f_req(f_req),
      .d_req(d_req),
      .f_gnt(f_gnt),
      .d_gnt(d_gnt)
   );

   // addr_q only changes on a grant, so the ROM address holds while idle.
   assign rom_addr = addr_q_r;
   assign oor_s    = (32'(addr_q_r) >= 32'(ROM_DEPTH));

   // Out-of-range reads return zero regardless of what the ROM drives.
   always_comb begin
      rdata_s = {DATA_W{1'b0}};
      if (oor_s) begin
         rdata_s = {DATA_W{1'b0}};
      end else begin
         rdata_s = rom_data;
      end
   end

   // Stage 1: capture the winner's address and port.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         addr_q_r   <= {ADDR_W{1'b0}};
         sel_q_r    <= PORT_F;
      end else if (f_gnt) begin
         s1_valid_r <= 1'b1;
         addr_q_r   <= f_addr;
         sel_q_r    <= PORT_F;
      end else if (d_gnt) begin
         s1_valid_r <= 1'b1;
         addr_q_r   <= d_addr;
         sel_q_r    <= PORT_D;
      end else begin
         s1_valid_r <= 1'b0;
         addr_q_r   <= addr_q_r;
         sel_q_r    <= sel_q_r;
      end
   end

   // Stage 2: register ROM data into the winning port's return path.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_valid_r <= 1'b0;
         d_valid_r <= 1'b0;
         f_err_r   <= 1'b0;
         d_err_r   <= 1'b0;
         f_rdata_r <= {DATA_W{1'b0}};
         d_rdata_r <= {DATA_W{1'b0}};
      end else if (s1_valid_r && (sel_q_r == PORT_F)) begin
         f_valid_r <= 1'b1;
         f_err_r   <= oor_s;
         f_rdata_r <= rdata_s;
         d_valid_r <= 1'b0;
         d_err_r   <= 1'b0;
         d_rdata_r <= d_rdata_r;
      end else if (s1_valid_r) begin
         d_valid_r <= 1'b1;
         d_err_r   <= oor_s;
         d_rdata_r <= rdata_s;
         f_valid_r <= 1'b0;
         f_err_r   <= 1'b0;
         f_rdata_r <= f_rdata_r;
      end else begin
         f_valid_r <= 1'b0;
         d_valid_r <= 1'b0;
         f_err_r   <= 1'b0;
         d_err_r   <= 1'b0;
         f_rdata_r <= f_rdata_r;
         d_rdata_r <= d_rdata_r;
      end
   end

   // Saturating accepted-request counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_cnt_r <= {CNT_W{1'b0}};
         d_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (f_gnt) begin
            f_cnt_r <= sat_inc(f_cnt_r);
         end else begin
            f_cnt_r <= f_cnt_r;
         end
         if (d_gnt) begin
            d_cnt_r <= sat_inc(d_cnt_r);
         end else begin
            d_cnt_r <= d_cnt_r;
         end
      end
   end

   assign f_valid = f_valid_r;
   assign d_valid = d_valid_r;
   assign f_err   = f_err_r;
   assign d_err   = d_err_r;
   assign f_rdata = f_rdata_r;
   assign d_rdata = d_rdata_r;
   assign f_cnt   = f_cnt_r;
   assign d_cnt   = d_cnt_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench: a round-robin instance (ROM_DEPTH 1024) and a fetch-priority
// instance (ROM_DEPTH 512), each fed by its own copy of the ROM model.
module tb_imem_arbiter;
   import cpu_pkg::*;

   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          a_f_req, a_d_req, a_f_gnt, a_d_gnt, a_f_valid, a_d_valid, a_f_err, a_d_err;
   logic [AW-1:0] a_f_addr, a_d_addr, a_rom_addr;
   logic [DW-1:0] a_f_rdata, a_d_rdata, a_rom_data;
   logic [15:0]   a_f_cnt, a_d_cnt;
   logic          b_f_req, b_d_req, b_f_gnt, b_d_gnt, b_f_valid, b_d_valid, b_f_err, b_d_err;
   logic [AW-1:0] b_f_addr, b_d_addr, b_rom_addr;
   logic [DW-1:0] b_f_rdata, b_d_rdata, b_rom_data;
   logic [15:0]   b_f_cnt, b_d_cnt;

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
      case (a)
         10'd0:   rom_word = 32'h0010_0093;
         10'd1:   rom_word = 32'h0100_006F;
         10'd5:   rom_word = 32'h0100_006F;
         default: rom_word = {16'hC0DE, 6'b000000, a};
      endcase
   endfunction

   assign a_rom_data = rom_word(a_rom_addr);
   assign b_rom_data = rom_word(b_rom_addr);

   imem_arbiter #(.ROM_DEPTH(1024), .FETCH_PRIO(0), .STARVE_MAX(4)) dut_a (
      .clk(clk), .rst(rst),
      .f_req(a_f_req), .f_addr(a_f_addr), .f_gnt(a_f_gnt), .f_valid(a_f_valid),
      .f_rdata(a_f_rdata), .f_err(a_f_err),
      .d_req(a_d_req), .d_addr(a_d_addr), .d_gnt(a_d_gnt), .d_valid(a_d_valid),
      .d_rdata(a_d_rdata), .d_err(a_d_err),
      .rom_addr(a_rom_addr), .rom_data(a_rom_data), .f_cnt(a_f_cnt), .d_cnt(a_d_cnt)
   );

   imem_arbiter #(.ROM_DEPTH(512), .FETCH_PRIO(1), .STARVE_MAX(4)) dut_b (
      .clk(clk), .rst(rst),
      .f_req(b_f_req), .f_addr(b_f_addr), .f_gnt(b_f_gnt), .f_valid(b_f_valid),
      .f_rdata(b_f_rdata), .f_err(b_f_err),
      .d_req(b_d_req), .d_addr(b_d_addr), .d_gnt(b_d_gnt), .d_valid(b_d_valid),
      .d_rdata(b_d_rdata), .d_err(b_d_err),
      .rom_addr(b_rom_addr), .rom_data(b_rom_data), .f_cnt(b_f_cnt), .d_cnt(b_d_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled at the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_all();
      a_f_req = 1'b0; a_d_req = 1'b0;
      b_f_req = 1'b0; b_d_req = 1'b0;
   endtask

   task automatic do_reset();
      step(); rst = 1'b1; idle_all(); mid();
      step(); rst = 1'b0; mid();
   endtask

   initial begin
      rst = 1'b1;
      idle_all();
      a_f_addr = '0; a_d_addr = '0; b_f_addr = '0; b_d_addr = '0;

      // Grant must stay low while reset is held, even with a request present.
      step(); a_f_req = 1'b1; mid();
      chk("gnt_in_rst", {a_f_gnt, a_d_gnt}, 2'b00);
      step(); rst = 1'b0; a_f_req = 1'b0; mid();
      chk("rst_flags", {a_f_gnt, a_d_gnt, a_f_valid, a_d_valid, a_f_err, a_d_err}, 6'b0);
      chk("rst_rdata", {a_f_rdata, a_d_rdata}, 64'h0);
      chk("rst_romaddr", a_rom_addr, 10'd0);
      chk("rst_cnt", {a_f_cnt, a_d_cnt}, 32'h0);

      // Single fetch read of word 0.
      step(); a_f_req = 1'b1; a_f_addr = 10'd0; mid();
      chk("single_gnt", {a_f_gnt, a_d_gnt}, 2'b10);
      step(); a_f_req = 1'b0; mid();
      chk("single_n1_valid", {a_f_valid, a_d_valid}, 2'b00);
      step(); mid();
      chk("single_n2_valid", {a_f_valid, a_d_valid}, 2'b10);
      chk("single_rdata", a_f_rdata, 32'h0010_0093);
      chk("single_err", a_f_err, 1'b0);
      step(); mid();
      chk("single_n3_valid", {a_f_valid, a_d_valid}, 2'b00);

      // Round-robin with both ports requesting every cycle.
      do_reset();
      for (int k = 0; k < 7; k++) begin
         step();
         if (k < 4) begin
            a_f_req = 1'b1; a_d_req = 1'b1; a_f_addr = 10'd1; a_d_addr = 10'd5;
         end else begin
            a_f_req = 1'b0; a_d_req = 1'b0;
         end
         mid();
         if (k < 4) chk($sformatf("rr_gnt%0d", k), {a_f_gnt, a_d_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
         if (k >= 2 && k < 6) begin
            chk($sformatf("rr_valid%0d", k), {a_f_valid, a_d_valid}, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("rr_rdata%0d", k), (k % 2 == 0) ? a_f_rdata : a_d_rdata, 32'h0100_006F);
         end else begin
            chk($sformatf("rr_novalid%0d", k), {a_f_valid, a_d_valid}, 2'b00);
         end
         if (k == 2) chk("rr_romaddr", a_rom_addr, 10'd5);
         if (k == 4) chk("rr_cnt", {a_f_cnt, a_d_cnt}, {16'd2, 16'd2});
         if (k == 6) chk("rr_romaddr_hold", a_rom_addr, 10'd5);
      end

      // A lone debug request is granted even though debug was granted last.
      step(); a_d_req = 1'b1; mid();
      chk("rr_single_d", {a_f_gnt, a_d_gnt}, 2'b01);
      step(); a_d_req = 1'b0; mid();

      // Reset in the cycle after a grant discards the access.
      step(); a_f_req = 1'b1; a_f_addr = 10'd1; mid();
      chk("flush_gnt", a_f_gnt, 1'b1);
      step(); a_f_req = 1'b0; rst = 1'b1; mid();
      step(); rst = 1'b0; mid();
      chk("flush_flags", {a_f_gnt, a_d_gnt, a_f_valid, a_d_valid, a_f_err, a_d_err}, 6'b0);
      chk("flush_rdata", {a_f_rdata, a_d_rdata}, 64'h0);
      chk("flush_romaddr", a_rom_addr, 10'd0);
      chk("flush_cnt", {a_f_cnt, a_d_cnt}, 32'h0);
      step(); mid();
      chk("flush_novalid", {a_f_valid, a_d_valid}, 2'b00);

      // Counter saturation starting from 0xFFFE.
      step(); force dut_a.f_cnt_r = 16'hFFFE; mid();
      step(); release dut_a.f_cnt_r; mid();
      chk("sat_preset", a_f_cnt, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         step(); a_f_req = 1'b1; a_f_addr = 10'(i + 2); mid();
         if (i == 1) chk("sat_first", a_f_cnt, 16'hFFFF);
      end
      step(); a_f_req = 1'b0; mid();
      chk("sat_hold", a_f_cnt, 16'hFFFF);
      chk("sat_dcnt", a_d_cnt, 16'h0000);

      // Fetch-priority: four fetch grants, then one debug grant, repeating.
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step(); b_f_req = 1'b1; b_d_req = 1'b1; b_f_addr = 10'd1; b_d_addr = 10'd5; mid();
         chk($sformatf("fp_gnt%0d", k), {b_f_gnt, b_d_gnt}, (k % 5 == 4) ? 2'b01 : 2'b10);
      end
      step(); b_f_req = 1'b0; b_d_req = 1'b0; mid();
      chk("fp_cnt", {b_f_cnt, b_d_cnt}, {16'd8, 16'd2});

      // Last in-range word, then the first out-of-range address.
      step(); b_f_req = 1'b1; b_f_addr = 10'd511; mid();
      chk("oor_fgnt", b_f_gnt, 1'b1);
      step(); b_f_req = 1'b0; b_d_req = 1'b1; b_d_addr = 10'd512; mid();
      chk("oor_dgnt", b_d_gnt, 1'b1);
      step(); b_d_req = 1'b0; mid();
      chk("inrange_valid", {b_f_valid, b_d_valid}, 2'b10);
      chk("inrange_rdata", b_f_rdata, rom_word(10'd511));
      chk("inrange_err", b_f_err, 1'b0);
      step(); mid();
      chk("oor_valid", {b_f_valid, b_d_valid}, 2'b01);
      chk("oor_rdata", b_d_rdata, 32'h0);
      chk("oor_err", b_d_err, 1'b1);
      step(); mid();
      chk("oor_done", {b_d_valid, b_d_err}, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
